wall_probe: RTL

Collision query engine: the requesting side of the map's pixel→is_Wall lookup. Once per frame, on a start pulse, it sweeps probe points one pixel outside a character's bounding box through the map module and accumulates the results into four direction-blocked flags. Character motion logic uses these flags to decide legal moves. One probe per clock, fixed latency.

---
 rtl/wall_probe.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/wall_probe.sv
// Sweeps probe points one pixel outside a character box through the map lookup; one probe per clock.
// Fixed latency: done pulses 2*NX+2*NY cycles after an accepted start; start is ignored unless idle.
module wall_probe #(
   parameter int CHAR_W     = 25,
   parameter int CHAR_H     = 33,
   parameter int PROBE_STEP = 4,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   input  logic [9:0] Pos_X,
   input  logic [9:0] Pos_Y,
   output logic [9:0] Probe_X,
   output logic [9:0] Probe_Y,
   output logic       Probe_Valid,
   input  logic       Probe_is_Wall,
   output logic       busy,
   output logic       done,
   output logic       blocked_down,
   output logic       blocked_up,
   output logic       blocked_left,
   output logic       blocked_right
);

   localparam int NX = (CHAR_W - 1) / PROBE_STEP + 1;
   localparam int NY = (CHAR_H - 1) / PROBE_STEP + 1;

   generate
      if (((CHAR_W - 1) % PROBE_STEP) != 0 || ((CHAR_H - 1) % PROBE_STEP) != 0) begin : g_bad_step
         $error("wall_probe: CHAR_W-1 and CHAR_H-1 must be multiples of PROBE_STEP");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SWEEP_DOWN,
      SWEEP_UP,
      SWEEP_LEFT,
      SWEEP_RIGHT,
      FINISH
   } state_t;

   typedef struct packed {
      logic signed [10:0] x;
      logic signed [10:0] y;
   } pt_t;

   state_t             state_q, state_d;
   logic [7:0]         k_q, k_d;
   logic signed [10:0] pos_x_q, pos_x_d;
   logic signed [10:0] pos_y_q, pos_y_d;
   logic [9:0]         probe_x_q, probe_x_d;
   logic [9:0]         probe_y_q, probe_y_d;
   logic               oor_q, oor_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [3:0]         acc_q, acc_d;
   logic [3:0]         blocked_q, blocked_d;

   logic               hit;
   logic               last;
   logic               load;
   logic [1:0]         dir;
   pt_t                pt;

   // Raw (unclamped) coordinate of probe k on the edge selected by s.
   function automatic pt_t probe_pt(input state_t s, input logic [7:0] k,
                                    input logic signed [10:0] bx, input logic signed [10:0] by);
      pt_t                p;
      logic signed [10:0] off;
      off = $signed(11'(k) * 11'(PROBE_STEP));
      p.x = bx;
      p.y = by;
      case (s)
         SWEEP_DOWN: begin
            p.x = bx + off;
            p.y = by + $signed(11'(CHAR_H));
         end
         SWEEP_UP: begin
            p.x = bx + off;
            p.y = by - 11'sd1;
         end
         SWEEP_LEFT: begin
            p.x = bx - 11'sd1;
            p.y = by + off;
         end
         SWEEP_RIGHT: begin
            p.x = bx + $signed(11'(CHAR_W));
            p.y = by + off;
         end
         default: ;
      endcase
      return p;
   endfunction

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      probe_x_d = probe_x_q;
      probe_y_d = probe_y_q;
      oor_d     = oor_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      acc_d     = acc_q;
      blocked_d = blocked_q;
      hit       = Probe_is_Wall | oor_q;
      last      = 1'b0;
      load      = 1'b0;
      dir       = 2'd0;

      case (state_q)
         IDLE: begin
            if (start) begin
               pos_x_d = $signed({1'b0, Pos_X});
               pos_y_d = $signed({1'b0, Pos_Y});
               state_d = SWEEP_DOWN;
               k_d     = 8'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               acc_d   = 4'd0;
               load    = 1'b1;
            end
         end
         SWEEP_DOWN, SWEEP_UP, SWEEP_LEFT, SWEEP_RIGHT: begin
            case (state_q)
               SWEEP_DOWN: begin dir = 2'd0; last = (k_q == 8'(NX - 1)); end
               SWEEP_UP:   begin dir = 2'd1; last = (k_q == 8'(NX - 1)); end
               SWEEP_LEFT: begin dir = 2'd2; last = (k_q == 8'(NY - 1)); end
               default:    begin dir = 2'd3; last = (k_q == 8'(NY - 1)); end
            endcase
            acc_d[dir] = acc_q[dir] | hit;
            if (!last) begin
               k_d  = k_q + 8'd1;
               load = 1'b1;
            end else begin
               k_d = 8'd0;
               case (state_q)
                  SWEEP_DOWN: begin state_d = SWEEP_UP;    load = 1'b1; end
                  SWEEP_UP:   begin state_d = SWEEP_LEFT;  load = 1'b1; end
                  SWEEP_LEFT: begin state_d = SWEEP_RIGHT; load = 1'b1; end
                  default: begin
                     state_d   = FINISH;
                     valid_d   = 1'b0;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     blocked_d = acc_d;
                  end
               endcase
            end
         end
         FINISH: begin
            state_d = IDLE;
            acc_d   = 4'd0;
         end
         default: state_d = IDLE;
      endcase

      // Off-screen points still take their cycle: drive a clamped address and force a hit.
      pt = probe_pt(state_d, k_d, pos_x_d, pos_y_d);
      if (load) begin
         oor_d = (pt.x < 0) || (pt.x >= $signed(11'(SCREEN_W))) ||
                 (pt.y < 0) || (pt.y >= $signed(11'(SCREEN_H)));
         if (pt.x < 0)
            probe_x_d = 10'd0;
         else if (pt.x >= $signed(11'(SCREEN_W)))
            probe_x_d = 10'(SCREEN_W - 1);
         else
            probe_x_d = pt.x[9:0];
         if (pt.y < 0)
            probe_y_d = 10'd0;
         else if (pt.y >= $signed(11'(SCREEN_H)))
            probe_y_d = 10'(SCREEN_H - 1);
         else
            probe_y_d = pt.y[9:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         k_q       <= 8'd0;
         pos_x_q   <= 11'sd0;
         pos_y_q   <= 11'sd0;
         probe_x_q <= 10'd0;
         probe_y_q <= 10'd0;
         oor_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         acc_q     <= 4'd0;
         blocked_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         probe_x_q <= probe_x_d;
         probe_y_q <= probe_y_d;
         oor_q     <= oor_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         acc_q     <= acc_d;
         blocked_q <= blocked_d;
      end
   end

   assign Probe_X       = probe_x_q;
   assign Probe_Y       = probe_y_q;
   assign Probe_Valid   = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign blocked_down  = blocked_q[0];
   assign blocked_up    = blocked_q[1];
   assign blocked_left  = blocked_q[2];
   assign blocked_right = blocked_q[3];

endmodule
